// File: rtl/encrypt_pipe_shift_dc_multi.sv
// rtl/encrypt_pipe_shift_dc_multi.sv - multi-lane character classifier with rotating key schedule
// Output register plus skid register; in_ready is registered and drops only while the skid holds a beat.
module encrypt_pipe_shift_dc_multi #(
  parameter int LANES    = 1,
  parameter int DIGIT_EN = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*LANES-1:0]    din,
  input  logic [7:0]            k1,
  input  logic [7:0]            k2,
  input  logic [7:0]            k3,
  input  logic [2:0]            rot_freq,
  input  logic                  shift_en,
  input  logic                  mode,
  input  logic                  sync_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_data,
  output logic [2*LANES-1:0]    out_class,
  output logic [8*LANES-1:0]    out_key,
  output logic                  out_mode,
  output logic                  out_shift_en
);

  localparam int PW = 42*LANES + 2;
  localparam logic [3:0] LANES4 = 4'(LANES);

  logic [2:0]  p, p_base, p_eff, p_next;
  logic [1:0]  ki, ki_base, ki_next;
  logic [3:0]  rf4, sum_n;
  logic        acc, upd;

  logic [32*LANES-1:0] c_data;
  logic [2*LANES-1:0]  c_class;
  logic [8*LANES-1:0]  c_key;
  logic [PW-1:0]       in_pl, out_pl, skid_pl;
  logic                skid_v;

  assign acc   = in_valid & in_ready;
  assign upd   = acc & shift_en & (rot_freq != 3'd0);
  assign rf4   = {1'b0, rot_freq};
  assign in_pl = {mode, shift_en, c_key, c_class, c_data};
  assign {out_mode, out_shift_en, out_key, out_class, out_data} = out_pl;

  // A cleared schedule is visible to the beat accepted in the same cycle; a stale p past a
  // lowered rot_freq is clamped so the following character starts a new key.
  always_comb begin
    p_base  = sync_clr ? 3'd0 : p;
    ki_base = sync_clr ? 2'd0 : ki;
    p_eff   = (rot_freq != 3'd0 && p_base >= rot_freq) ? rot_freq - 3'd1 : p_base;
    sum_n   = {1'b0, p_eff} + LANES4;
    p_next  = 3'd0;
    ki_next = ki_base;
    if (rot_freq != 3'd0) begin
      p_next  = 3'(sum_n % rf4);
      ki_next = 2'((4'(ki_base) + sum_n / rf4) % 4'd3);
    end
  end

  always_comb begin
    logic [7:0] ch;
    logic [3:0] sum;
    logic [1:0] idx;
    c_data  = '0;
    c_class = '0;
    c_key   = '0;
    for (int i = 0; i < LANES; i++) begin
      ch  = din[8*i +: 8];
      c_data[32*i +: 32] = {24'b0, ch};
      c_class[2*i +: 2]  = 2'b00;
      if (shift_en && mode) begin
        if (ch >= 8'd65 && ch <= 8'd90) begin
          c_class[2*i +: 2]  = 2'b01;
          c_data[32*i +: 32] = 32'd1 << (ch - 8'd65);
        end else if (ch >= 8'd97 && ch <= 8'd122) begin
          c_class[2*i +: 2]  = 2'b10;
          c_data[32*i +: 32] = 32'd1 << (ch - 8'd97);
        end else if (DIGIT_EN != 0 && ch >= 8'd48 && ch <= 8'd57) begin
          c_class[2*i +: 2]  = 2'b11;
          c_data[32*i +: 32] = 32'd1 << (ch - 8'd48);
        end
      end
      sum = {1'b0, p_eff} + 4'(i);
      idx = 2'd0;
      if (rot_freq != 3'd0)
        idx = 2'((4'(ki_base) + sum / rf4) % 4'd3);
      case (idx)
        2'd0:    c_key[8*i +: 8] = k1;
        2'd1:    c_key[8*i +: 8] = k2;
        default: c_key[8*i +: 8] = k3;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p         <= 3'd0;
      ki        <= 2'd0;
      out_valid <= 1'b0;
      skid_v    <= 1'b0;
      in_ready  <= 1'b0;
      out_pl    <= '0;
      skid_pl   <= '0;
    end else begin
      if (upd) begin
        p  <= p_next;
        ki <= ki_next;
      end else if (sync_clr) begin
        p  <= 3'd0;
        ki <= 2'd0;
      end

      if (skid_v) begin
        if (out_ready) begin
          out_pl   <= skid_pl;
          skid_v   <= 1'b0;
          in_ready <= 1'b1;
        end
      end else begin
        in_ready <= 1'b1;
        if (acc) begin
          if (!out_valid || out_ready) begin
            out_pl    <= in_pl;
            out_valid <= 1'b1;
          end else begin
            skid_pl  <= in_pl;
            skid_v   <= 1'b1;
            in_ready <= 1'b0;
          end
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_encrypt_pipe_shift_dc_multi.sv
// tb/tb_encrypt_pipe_shift_dc_multi.sv - directed bench for encrypt_pipe_shift_dc_multi
module tb_encrypt_pipe_shift_dc_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]   k1 = 8'd11, k2 = 8'd22, k3 = 8'd33;
  logic [2:0]   rot_freq = 3'd0;
  logic         shift_en = 1'b0, mode = 1'b0, sync_clr = 1'b0;

  logic         in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
  logic [7:0]   din1 = 8'd0;
  logic [31:0]  out_data1;
  logic [1:0]   out_class1;
  logic [7:0]   out_key1;
  logic         out_mode1, out_shift_en1;

  logic         in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1;
  logic [31:0]  din4 = 32'd0;
  logic [127:0] out_data4;
  logic [7:0]   out_class4;
  logic [31:0]  out_key4;
  logic         out_mode4, out_shift_en4;

  int checks = 0;
  int errors = 0;

  encrypt_pipe_shift_dc_multi #(.LANES(1), .DIGIT_EN(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .din(din1),
    .k1(k1), .k2(k2), .k3(k3), .rot_freq(rot_freq), .shift_en(shift_en), .mode(mode),
    .sync_clr(sync_clr), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_class(out_class1), .out_key(out_key1), .out_mode(out_mode1), .out_shift_en(out_shift_en1)
  );

  encrypt_pipe_shift_dc_multi #(.LANES(4), .DIGIT_EN(1)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .din(din4),
    .k1(k1), .k2(k2), .k3(k3), .rot_freq(rot_freq), .shift_en(shift_en), .mode(mode),
    .sync_clr(sync_clr), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_class(out_class4), .out_key(out_key4), .out_mode(out_mode4), .out_shift_en(out_shift_en4)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send1(input logic [7:0] c);
    din1      = c;
    in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
  endtask

  logic [7:0]  s36  [5] = '{8'h41, 8'h62, 8'h43, 8'h39, 8'h21};
  logic [31:0] d36  [5] = '{32'h1, 32'h2, 32'h4, 32'h39, 32'h21};
  logic [1:0]  c36  [5] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
  logic [7:0]  k36  [5] = '{8'd11, 8'd11, 8'd22, 8'd22, 8'd33};
  logic [7:0]  s39  [6] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
  logic [7:0]  got  [6];

  initial begin
    int sent, rcv;
    logic accd, fire;

    // reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready1, 0);
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_out_data", out_data1, 0);
    chk("rst_out_key4", out_key4, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready1, 1);

    // "AbC9!" with rot_freq=2
    rot_freq = 3'd2; mode = 1'b1; shift_en = 1'b1; out_ready1 = 1'b1;
    for (int j = 0; j < 5; j++) begin
      din1 = s36[j]; in_valid1 = 1'b1;
      @(negedge clk);
      chk("abc_valid", out_valid1, 1);
      chk("abc_data", out_data1, d36[j]);
      chk("abc_class", out_class1, c36[j]);
      chk("abc_key", out_key1, k36[j]);
    end
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("abc_drain", out_valid1, 0);

    // output stalled for 3 cycles with continuous input
    rot_freq = 3'd0; mode = 1'b0;
    sent = 0; rcv = 0;
    for (int cyc = 0; cyc < 24 && rcv < 6; cyc++) begin
      out_ready1 = (cyc >= 3);
      in_valid1  = (sent < 6);
      din1       = (sent < 6) ? s39[sent] : 8'd0;
      accd = in_valid1 && in_ready1;
      fire = out_valid1 && out_ready1;
      if (fire) begin
        got[rcv] = out_data1[7:0];
        rcv++;
      end
      if (cyc == 2) begin
        chk("stall_in_ready", in_ready1, 0);
        chk("stall_accepted", sent, 2);
        chk("stall_hold", out_data1, {24'b0, s39[0]});
      end
      @(negedge clk);
      if (accd) sent++;
    end
    in_valid1 = 1'b0;
    chk("stall_count", rcv, 6);
    for (int j = 0; j < 6; j++) chk("stall_order", got[j], s39[j]);

    // reset with both registers full
    sync_clr = 1'b1; @(negedge clk); sync_clr = 1'b0;
    rot_freq = 3'd2; mode = 1'b1; out_ready1 = 1'b0;
    din1 = 8'h41; in_valid1 = 1'b1; @(negedge clk);
    din1 = 8'h42; @(negedge clk);
    in_valid1 = 1'b0;
    chk("full_out_valid", out_valid1, 1);
    chk("full_in_ready", in_ready1, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid1, 0);
    chk("midrst_in_ready", in_ready1, 0);
    chk("midrst_out_data", out_data1, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    out_ready1 = 1'b1;
    send1(8'h41);
    chk("after_rst_key", out_key1, 11);

    // sync_clr together with an accepted beat
    send1(8'h41);
    chk("pre_clr_key", out_key1, 11);
    sync_clr = 1'b1;
    send1(8'h41);
    sync_clr = 1'b0;
    chk("clr_beat_key", out_key1, 11);
    send1(8'h41);
    chk("post_clr_key0", out_key1, 11);
    send1(8'h41);
    chk("post_clr_key1", out_key1, 22);

    // rot_freq lowered below the current position
    sync_clr = 1'b1; @(negedge clk); sync_clr = 1'b0;
    rot_freq = 3'd3;
    send1(8'h41); send1(8'h41);
    rot_freq = 3'd1;
    send1(8'h41);
    chk("clamp_key0", out_key1, 11);
    send1(8'h41);
    chk("clamp_key1", out_key1, 22);

    // four lanes, rot_freq=3, schedule cleared
    sync_clr = 1'b1; @(negedge clk); sync_clr = 1'b0;
    rot_freq = 3'd3; mode = 1'b1; shift_en = 1'b1;
    din4 = {4{8'h7a}}; in_valid4 = 1'b1;
    @(negedge clk);
    chk("z1_key", out_key4, {8'd22, 8'd11, 8'd11, 8'd11});
    chk("z1_data", out_data4, {4{32'h2000000}});
    chk("z1_class", out_class4, {4{2'b10}});
    @(negedge clk);
    chk("z2_key", out_key4, {8'd33, 8'd33, 8'd22, 8'd22});
    @(negedge clk);
    chk("z3_key", out_key4, {8'd11, 8'd11, 8'd11, 8'd33});

    // digit class enabled, mixed lanes
    rot_freq = 3'd0;
    din4 = 32'h21615A37;
    @(negedge clk);
    chk("dig_class", out_class4, {2'b00, 2'b10, 2'b01, 2'b11});
    chk("dig_data", out_data4, {32'h21, 32'h1, 32'h2000000, 32'h80});
    chk("dig_key", out_key4, {4{8'd11}});
    mode = 1'b0;
    @(negedge clk);
    chk("m0_class", out_class4, 0);
    chk("m0_data", out_data4, {32'h21, 32'h61, 32'h5A, 32'h37});
    chk("m0_mode", out_mode4, 0);
    in_valid4 = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encrypt_pipe_shift_dc_multi.md
ENCRYPT_PIPE_SHIFT_DC_MULTI -- requirements
Module: encrypt_pipe_shift_dc_multi

Interface
REQ-001 Parameter LANES, default 1, characters per beat, legal 1..4.
REQ-002 Parameter DIGIT_EN, default 0, 1 enables digit class and digit one-hot.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  input beat valid.
REQ-006 in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
REQ-007 din  in  8*LANES  ASCII characters, lane i at [8i+7:8i], lane 0 is the earliest character.
REQ-008 k1, k2, k3  in  8 each  key bytes.
REQ-009 rot_freq  in  3  characters per key; 0 means no rotation.
REQ-010 shift_en, mode  in  1 each  shift cipher enable; 1 = encrypt.
REQ-011 sync_clr  in  1  synchronous clear of the key schedule.
REQ-012 out_valid  out  1  output beat valid.
REQ-013 out_ready  in  1  downstream accepts when out_valid and out_ready are both high.
REQ-014 out_data  out  32*LANES  per-lane extended field.
REQ-015 out_class  out  2*LANES  per-lane class: 00 other, 01 upper, 10 lower, 11 digit.
REQ-016 out_key  out  8*LANES  per-lane selected key.
REQ-017 out_mode, out_shift_en  out  1 each  mode and shift_en registered with the beat.

Function
REQ-018 Per-lane classification SHALL be active only when shift_en=1 and mode=1.
- Upper: 65..90 gives class 01 and a one-hot at bit din-65.
- Lower: 97..122 gives class 10 and a one-hot at bit din-97.
- Digit: 48..57 with DIGIT_EN=1 gives class 11 and a one-hot at bit din-48.
- Any other character gives class 00 and data {24'b0, din}.
REQ-019 When shift_en=0 or mode=0, every lane SHALL output class 00 with data {24'b0, din}.
REQ-020 out_data bits [31:26] SHALL be 0 in all one-hot cases.
REQ-021 The key schedule SHALL hold a position counter p (0..6) and a key index ki (0..2, mapping 0=k1, 1=k2, 2=k3).
REQ-022 Lane i key index SHALL be (ki + floor((p+i)/rot_freq)) mod 3 when rot_freq!=0, else 0.
REQ-023 On each accepted beat with shift_en=1 and rot_freq!=0:
- p_next = (p+LANES) mod rot_freq.
- ki_next = (ki + floor((p+LANES)/rot_freq)) mod 3.
REQ-024 Beats with shift_en=0, or beats that are not accepted, SHALL leave p and ki unchanged.
REQ-025 If rot_freq is lowered so that p >= rot_freq, p SHALL be treated as rot_freq-1 for that beat, so the next character starts a new key.
REQ-026 sync_clr SHALL set p=0 and ki=0 and take priority over the update.
- A beat accepted in the same cycle SHALL use the already-cleared values p=0, ki=0.
REQ-027 Latency SHALL be 1 cycle from acceptance to out_valid when the output is not stalled.
REQ-028 Output side SHALL be an output register plus one skid register; sustained throughput SHALL be 1 beat per cycle.
REQ-029 in_ready SHALL be a register output that is low exactly when the skid register is occupied.
REQ-030 Beat order SHALL be preserved.
- The skid beat moves to the output register on the first out_ready cycle.
- in_ready rises on the following cycle.
REQ-031 Output fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-032 No beat SHALL be dropped or duplicated under any in_valid/out_ready pattern.

Reset
REQ-033 While rst=1, every output except in_ready SHALL be 0; p, ki and both registers SHALL be 0 and empty.
REQ-034 While rst=1, in_ready SHALL be 0; it SHALL be 1 in the first cycle after release.
REQ-035 Reset asserted mid-stream SHALL discard buffered beats immediately.

Verification
REQ-036 LANES=1, rot_freq=2, mode=1, shift_en=1, k=11/22/33, out_ready=1, input "AbC9!" (DIGIT_EN=0) -> required outputs:
- data 0x1, 0x2, 0x4, 0x39, 0x21
- class 01, 10, 01, 00, 00
- keys 11, 11, 22, 22, 33
REQ-037 LANES=4, rot_freq=3, from reset, two beats of "zzzz" -> required outputs:
- Beat 1 keys k1, k1, k1, k2; each data 0x2000000; after it p=1, ki=1.
- Beat 2 keys k2, k2, k3, k3; after it p=2, ki=2.
REQ-038 DIGIT_EN=1, din '7', mode=1, shift_en=1 -> class 11, data 0x80; with mode=0 -> class 00, data 0x37.
REQ-039 out_ready held 0 for 3 cycles with in_valid=1 continuous -> required behaviour:
- Two beats are accepted.
- in_ready falls.
- After out_ready=1, beats emerge in order with no loss.
REQ-040 rst pulsed while both registers are full -> out_valid=0 immediately, p=ki=0; sync_clr with an accepted beat -> that beat gets key k1.
